// File: rtl/soc_network_adapter_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : soc_network_adapter_mem_responder
// Purpose  : NoC-side memory responder for the tile DMA engine. Accepts read
//            and write request packets on one flit channel, performs word
//            accesses on a blackbone bus master port, and returns a write
//            acknowledge or a read-data packet on the response channel.
//            One packet in flight at a time, responses in request order.
// Ports    : clk, rst (asynchronous, active-low)
//            noc_in_*   request flit channel  (flit/last/valid in, ready out)
//            noc_out_*  response flit channel (flit/last/valid out, ready in)
//            bbm_*      bus master: addr/din/en/we out, dout in (1-cycle read)
// Revision : 1.0  initial release
// ============================================================================
module soc_network_adapter_mem_responder #(
    parameter int           AW        = 32,
    parameter int           DW        = 32,
    parameter logic [4:0]   TILEID    = 5'd0,
    parameter logic [2:0]   RES_CLASS = 3'd1,
    parameter int           MAX_BURST = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     noc_in_flit,
    input  logic            noc_in_last,
    input  logic            noc_in_valid,
    output logic            noc_in_ready,
    output logic [31:0]     noc_out_flit,
    output logic            noc_out_last,
    output logic            noc_out_valid,
    input  logic            noc_out_ready,
    output logic [AW-1:0]   bbm_addr_o,
    output logic [DW-1:0]   bbm_din_o,
    output logic            bbm_en_o,
    output logic            bbm_we_o,
    input  logic [DW-1:0]   bbm_dout_i
);

    localparam logic [10:0]   c_max_burst = 11'(MAX_BURST);
    localparam logic [AW-1:0] c_word_step = AW'(4);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDR   = 4'd1,
        S_WDATA  = 4'd2,
        S_DROP   = 4'd3,
        S_WACK   = 4'd4,
        S_RHDR   = 4'd5,
        S_RISSUE = 4'd6,
        S_RWAIT  = 4'd7,
        S_RSEND  = 4'd8
    } state_t;

    // Response header layout mirrors the request header: destination is the
    // requester's source id, bits [18:14] and [11] are reserved (zero).
    function automatic logic [31:0] f_resp_hdr(
        input logic [4:0]  dest,
        input logic        err,
        input logic        we,
        input logic [10:0] len
    );
        f_resp_hdr = {dest, RES_CLASS, TILEID, 5'd0, err, we, 1'b0, len};
    endfunction

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t         r_state;
    logic [4:0]     r_src;
    logic           r_we;
    logic [10:0]    r_len;
    logic [10:0]    r_count;
    logic [AW-1:0]  r_addr;
    logic           r_in_ready;
    logic [31:0]    r_out_flit;
    logic           r_out_last;
    logic           r_out_valid;
    logic [AW-1:0]  r_bus_addr;
    logic [DW-1:0]  r_bus_din;
    logic           r_bus_en;
    logic           r_bus_we;

    state_t         w_state_n;
    logic [4:0]     w_src_n;
    logic           w_we_n;
    logic [10:0]    w_len_n;
    logic [10:0]    w_count_n;
    logic [AW-1:0]  w_addr_n;
    logic           w_in_ready_n;
    logic [31:0]    w_out_flit_n;
    logic           w_out_last_n;
    logic           w_out_valid_n;
    logic [AW-1:0]  w_bus_addr_n;
    logic [DW-1:0]  w_bus_din_n;
    logic           w_bus_en_n;
    logic           w_bus_we_n;

    logic           w_in_acc;
    logic           w_out_acc;
    logic [10:0]    w_count_inc;
    logic [AW-1:0]  w_addr_inc;
    logic           w_len_bad;

    assign w_in_acc    = noc_in_valid & r_in_ready;
    assign w_out_acc   = r_out_valid & noc_out_ready;
    assign w_count_inc = r_count + 11'd1;
    assign w_addr_inc  = r_addr + c_word_step;   // wraps modulo 2^AW
    assign w_len_bad   = (r_len == 11'd0) || (r_len > c_max_burst);

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Every output is computed here one
    // cycle ahead and registered below, so the flit registers only change on
    // entry into a presenting state and stay stable while stalled.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_n     = r_state;
        w_src_n       = r_src;
        w_we_n        = r_we;
        w_len_n       = r_len;
        w_count_n     = r_count;
        w_addr_n      = r_addr;
        w_out_flit_n  = r_out_flit;
        w_out_last_n  = r_out_last;
        w_bus_addr_n  = r_bus_addr;
        w_bus_din_n   = r_bus_din;
        w_bus_en_n    = 1'b0;
        w_bus_we_n    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_in_acc) begin
                    w_src_n   = noc_in_flit[23:19];
                    w_we_n    = noc_in_flit[12];
                    w_len_n   = noc_in_flit[10:0];
                    w_count_n = 11'd0;
                    if (noc_in_last) begin
                        // Header-only packet: nothing to drain, answer at once.
                        w_state_n    = S_WACK;
                        w_out_flit_n = f_resp_hdr(noc_in_flit[23:19], 1'b1, 1'b1, 11'd0);
                        w_out_last_n = 1'b1;
                    end else begin
                        w_state_n = S_ADDR;
                    end
                end
            end

            S_ADDR: begin
                if (w_in_acc) begin
                    w_addr_n = AW'(noc_in_flit);
                    if (w_len_bad || (r_we && noc_in_last)) begin
                        if (noc_in_last) begin
                            w_state_n    = S_WACK;
                            w_out_flit_n = f_resp_hdr(r_src, 1'b1, 1'b1, 11'd0);
                            w_out_last_n = 1'b1;
                        end else begin
                            w_state_n = S_DROP;
                        end
                    end else if (r_we) begin
                        w_state_n = S_WDATA;
                    end else if (noc_in_last) begin
                        w_state_n    = S_RHDR;
                        w_out_flit_n = f_resp_hdr(r_src, 1'b0, 1'b0, r_len);
                        w_out_last_n = 1'b0;
                    end else begin
                        // Read request carrying extra flits is malformed.
                        w_state_n = S_DROP;
                    end
                end
            end

            S_WDATA: begin
                if (w_in_acc) begin
                    w_bus_en_n   = 1'b1;
                    w_bus_we_n   = 1'b1;
                    w_bus_addr_n = r_addr;
                    w_bus_din_n  = DW'(noc_in_flit);
                    w_addr_n     = w_addr_inc;
                    w_count_n    = w_count_inc;
                    if (noc_in_last) begin
                        // Short packet reports error with the words written.
                        w_state_n    = S_WACK;
                        w_out_flit_n = f_resp_hdr(r_src, (w_count_inc != r_len), 1'b1, w_count_inc);
                        w_out_last_n = 1'b1;
                    end else if (w_count_inc == r_len) begin
                        w_state_n = S_DROP;
                    end
                end
            end

            S_DROP: begin
                if (w_in_acc && noc_in_last) begin
                    w_state_n    = S_WACK;
                    w_out_flit_n = f_resp_hdr(r_src, 1'b1, 1'b1, r_count);
                    w_out_last_n = 1'b1;
                end
            end

            S_WACK: begin
                if (w_out_acc) begin
                    w_state_n = S_IDLE;
                end
            end

            S_RHDR: begin
                if (w_out_acc) begin
                    w_state_n    = S_RISSUE;
                    w_bus_en_n   = 1'b1;
                    w_bus_addr_n = r_addr;
                end
            end

            S_RISSUE: begin
                // Strobe is already on the bus this cycle; data follows next.
                w_state_n = S_RWAIT;
            end

            S_RWAIT: begin
                w_state_n    = S_RSEND;
                w_out_flit_n = 32'(bbm_dout_i);
                w_out_last_n = (r_count == (r_len - 11'd1));
            end

            S_RSEND: begin
                if (w_out_acc) begin
                    w_addr_n  = w_addr_inc;
                    w_count_n = w_count_inc;
                    if (w_count_inc == r_len) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n    = S_RISSUE;
                        w_bus_en_n   = 1'b1;
                        w_bus_addr_n = w_addr_inc;
                    end
                end
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_in_ready_n  = (w_state_n == S_IDLE) || (w_state_n == S_ADDR) ||
                        (w_state_n == S_WDATA) || (w_state_n == S_DROP);
        w_out_valid_n = (w_state_n == S_WACK) || (w_state_n == S_RHDR) ||
                        (w_state_n == S_RSEND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_src       <= 5'd0;
            r_we        <= 1'b0;
            r_len       <= 11'd0;
            r_count     <= 11'd0;
            r_addr      <= '0;
            r_in_ready  <= 1'b0;
            r_out_flit  <= 32'd0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_din   <= '0;
            r_bus_en    <= 1'b0;
            r_bus_we    <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_src       <= w_src_n;
            r_we        <= w_we_n;
            r_len       <= w_len_n;
            r_count     <= w_count_n;
            r_addr      <= w_addr_n;
            r_in_ready  <= w_in_ready_n;
            r_out_flit  <= w_out_flit_n;
            r_out_last  <= w_out_last_n;
            r_out_valid <= w_out_valid_n;
            r_bus_addr  <= w_bus_addr_n;
            r_bus_din   <= w_bus_din_n;
            r_bus_en    <= w_bus_en_n;
            r_bus_we    <= w_bus_we_n;
        end
    end

    assign noc_in_ready  = r_in_ready;
    assign noc_out_flit  = r_out_flit;
    assign noc_out_last  = r_out_last;
    assign noc_out_valid = r_out_valid;
    assign bbm_addr_o    = r_bus_addr;
    assign bbm_din_o     = r_bus_din;
    assign bbm_en_o      = r_bus_en;
    assign bbm_we_o      = r_bus_we;

endmodule
`default_nettype wire

// File: tb/tb_soc_network_adapter_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_network_adapter_mem_responder
// Purpose  : Directed scoreboard bench for the NoC memory responder. Expected
//            response flits and bus accesses are queued when stimulus is
//            driven and compared by monitors as the design produces them.
// Revision : 1.0  initial release
// ============================================================================
module tb_soc_network_adapter_mem_responder;

    localparam logic [4:0] c_tile = 5'd9;
    localparam logic [2:0] c_cls  = 3'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] noc_in_flit;
    logic        noc_in_last;
    logic        noc_in_valid;
    logic        noc_in_ready;
    logic [31:0] noc_out_flit;
    logic        noc_out_last;
    logic        noc_out_valid;
    logic        noc_out_ready;
    logic [31:0] bbm_addr_o;
    logic [31:0] bbm_din_o;
    logic        bbm_en_o;
    logic        bbm_we_o;
    logic [31:0] bbm_dout_i;

    always #5 clk = ~clk;

    soc_network_adapter_mem_responder #(
        .AW(32), .DW(32), .TILEID(c_tile), .RES_CLASS(c_cls), .MAX_BURST(256)
    ) dut (
        .clk(clk), .rst(rst),
        .noc_in_flit(noc_in_flit), .noc_in_last(noc_in_last),
        .noc_in_valid(noc_in_valid), .noc_in_ready(noc_in_ready),
        .noc_out_flit(noc_out_flit), .noc_out_last(noc_out_last),
        .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready),
        .bbm_addr_o(bbm_addr_o), .bbm_din_o(bbm_din_o),
        .bbm_en_o(bbm_en_o), .bbm_we_o(bbm_we_o), .bbm_dout_i(bbm_dout_i)
    );

    int total = 0;
    int bad   = 0;

    logic [32:0] q_resp [$];   // {last, flit}
    logic [64:0] q_bus  [$];   // {we, addr, din}
    logic [31:0] mem [logic [31:0]];

    logic        prev_acc  = 1'b0;
    logic [31:0] prev_flit = 32'd0;
    logic [32:0] e_resp;
    logic [64:0] e_bus;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] req_hdr(input logic [4:0] src, input logic we, input logic [10:0] len);
        req_hdr = {c_tile, 3'd0, src, 5'd0, 1'b0, we, 1'b0, len};
    endfunction

    function automatic logic [31:0] rsp_hdr(input logic [4:0] dest, input logic err,
                                            input logic we, input logic [10:0] len);
        rsp_hdr = {dest, c_cls, c_tile, 5'd0, err, we, 1'b0, len};
    endfunction

    // Bus memory model: read data valid exactly one cycle after the strobe.
    always @(posedge clk) begin
        bbm_dout_i <= 32'hDEAD_BEEF;
        if (bbm_en_o && !bbm_we_o) bbm_dout_i <= mem.exists(bbm_addr_o) ? mem[bbm_addr_o] : 32'h0;
        if (bbm_en_o && bbm_we_o) mem[bbm_addr_o] = bbm_din_o;
    end

    // Monitors sample at negedge: values seen here are those used at the next posedge.
    always @(negedge clk) begin
        if (noc_out_valid && noc_out_ready) begin
            if (q_resp.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                e_resp = q_resp.pop_front();
                chk("resp_flit", noc_out_flit, e_resp[31:0]);
                chk("resp_last", noc_out_last, e_resp[32]);
            end
        end
        if (bbm_en_o) begin
            if (q_bus.size() == 0) begin
                chk("bus_unexpected", {bbm_we_o, bbm_addr_o}, 0);
            end else begin
                e_bus = q_bus.pop_front();
                chk("bus_we", bbm_we_o, e_bus[64]);
                chk("bus_addr", bbm_addr_o, e_bus[63:32]);
                if (e_bus[64]) begin
                    chk("bus_din", bbm_din_o, e_bus[31:0]);
                    chk("wr_lag_acc", prev_acc, 1);
                    chk("wr_lag_data", prev_flit, e_bus[31:0]);
                end
            end
        end
        prev_acc  = noc_in_valid && noc_in_ready;
        prev_flit = noc_in_flit;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] f, input logic l);
        int n = 0;
        noc_in_flit  = f;
        noc_in_last  = l;
        noc_in_valid = 1'b1;
        @(negedge clk);
        while (!noc_in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!noc_in_ready) chk("in_ready_timeout", noc_in_ready, 1);
        tick();
        noc_in_valid = 1'b0;
        noc_in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!noc_out_valid && n < 200) begin
            n++;
            tick();
        end
        chk("out_valid_wait", noc_out_valid, 1);
    endtask

    task automatic pulse_ready();
        wait_valid();
        noc_out_ready = 1'b1;
        tick();
        noc_out_ready = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q_resp.size() != 0 || q_bus.size() != 0) && n < 400) begin
            n++;
            tick();
        end
        chk("drain", 64'(q_resp.size() + q_bus.size()), 0);
        repeat (3) tick();
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        q_bus.push_back({1'b1, a, d});
    endtask

    task automatic exp_rd(input logic [31:0] a, input logic last);
        q_bus.push_back({1'b0, a, 32'd0});
        q_resp.push_back({last, mem[a]});
    endtask

    initial begin
        rst           = 1'b0;
        noc_in_flit   = 32'd0;
        noc_in_last   = 1'b0;
        noc_in_valid  = 1'b0;
        noc_out_ready = 1'b1;
        mem[32'h200] = 32'h1111_AAAA;
        mem[32'h204] = 32'h2222_BBBB;
        mem[32'h208] = 32'h3333_CCCC;
        mem[32'h400] = 32'h4444_DDDD;
        mem[32'h404] = 32'h5555_EEEE;
        mem[32'h300] = 32'h6666_FFFF;
        mem[32'h304] = 32'h7777_0000;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", noc_in_ready, 0);
        chk("rst_out_valid", noc_out_valid, 0);
        chk("rst_out_last", noc_out_last, 0);
        chk("rst_out_flit", noc_out_flit, 0);
        chk("rst_en", bbm_en_o, 0);
        chk("rst_we", bbm_we_o, 0);
        chk("rst_addr", bbm_addr_o, 0);
        chk("rst_din", bbm_din_o, 0);
        rst = 1'b1;
        tick();

        // 1: write burst of 4
        for (int i = 0; i < 4; i++) exp_wr(32'h100 + 32'(i * 4), 32'hA0 + 32'(i));
        q_resp.push_back({1'b1, rsp_hdr(5'd3, 1'b0, 1'b1, 11'd4)});
        send(req_hdr(5'd3, 1'b1, 11'd4), 1'b0);
        send(32'h100, 1'b0);
        for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), (i == 3));
        wait_done();

        // 2: read burst of 3
        q_resp.push_back({1'b0, rsp_hdr(5'd5, 1'b0, 1'b0, 11'd3)});
        exp_rd(32'h200, 1'b0);
        exp_rd(32'h204, 1'b0);
        exp_rd(32'h208, 1'b1);
        send(req_hdr(5'd5, 1'b0, 11'd3), 1'b0);
        send(32'h200, 1'b1);
        wait_done();

        // 3: read of 2 with the response channel stalled mid-burst
        noc_out_ready = 1'b0;
        q_resp.push_back({1'b0, rsp_hdr(5'd6, 1'b0, 1'b0, 11'd2)});
        exp_rd(32'h400, 1'b0);
        exp_rd(32'h404, 1'b1);
        send(req_hdr(5'd6, 1'b0, 11'd2), 1'b0);
        send(32'h400, 1'b1);
        pulse_ready();
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("stall_flit", noc_out_flit, 32'h4444_DDDD);
            chk("stall_last", noc_out_last, 0);
            chk("stall_in_ready", noc_in_ready, 0);
            chk("stall_bus_en", bbm_en_o, 0);
            tick();
        end
        noc_out_ready = 1'b1;
        wait_done();

        // 4a: write of 4 terminated after 2 data flits
        exp_wr(32'h600, 32'hC0);
        exp_wr(32'h604, 32'hC1);
        q_resp.push_back({1'b1, rsp_hdr(5'd4, 1'b1, 1'b1, 11'd2)});
        send(req_hdr(5'd4, 1'b1, 11'd4), 1'b0);
        send(32'h600, 1'b0);
        send(32'hC0, 1'b0);
        send(32'hC1, 1'b1);
        wait_done();

        // 4b: zero-length write, and a burst above the limit
        q_resp.push_back({1'b1, rsp_hdr(5'd4, 1'b1, 1'b1, 11'd0)});
        send(req_hdr(5'd4, 1'b1, 11'd0), 1'b0);
        send(32'h700, 1'b1);
        wait_done();
        q_resp.push_back({1'b1, rsp_hdr(5'd8, 1'b1, 1'b1, 11'd0)});
        send(req_hdr(5'd8, 1'b0, 11'd300), 1'b0);
        send(32'h700, 1'b1);
        wait_done();

        // 5: write crossing the top of the address space
        exp_wr(32'hFFFF_FFFC, 32'hE0);
        exp_wr(32'h0000_0000, 32'hE1);
        q_resp.push_back({1'b1, rsp_hdr(5'd1, 1'b0, 1'b1, 11'd2)});
        send(req_hdr(5'd1, 1'b1, 11'd2), 1'b0);
        send(32'hFFFF_FFFC, 1'b0);
        send(32'hE0, 1'b0);
        send(32'hE1, 1'b1);
        wait_done();

        // 6: asynchronous reset while a read data flit is pending
        noc_out_ready = 1'b0;
        q_resp.push_back({1'b0, rsp_hdr(5'd7, 1'b0, 1'b0, 11'd2)});
        q_bus.push_back({1'b0, 32'h300, 32'd0});
        send(req_hdr(5'd7, 1'b0, 11'd2), 1'b0);
        send(32'h300, 1'b1);
        pulse_ready();
        wait_valid();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", noc_out_valid, 0);
        chk("arst_out_flit", noc_out_flit, 0);
        chk("arst_out_last", noc_out_last, 0);
        chk("arst_in_ready", noc_in_ready, 0);
        chk("arst_en", bbm_en_o, 0);
        chk("arst_we", bbm_we_o, 0);
        chk("arst_addr", bbm_addr_o, 0);
        chk("arst_din", bbm_din_o, 0);
        tick();
        rst = 1'b1;
        noc_out_ready = 1'b1;
        chk("arst_pending", 64'(q_resp.size() + q_bus.size()), 0);
        exp_wr(32'h500, 32'hF0);
        q_resp.push_back({1'b1, rsp_hdr(5'd2, 1'b0, 1'b1, 11'd1)});
        send(req_hdr(5'd2, 1'b1, 11'd1), 1'b0);
        send(32'h500, 1'b0);
        send(32'hF0, 1'b1);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
